// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a frame-synchronous shadow
// register, leading-zero blanking and an optional all-off gap before each digit.
//
// state    | meaning
// ST_BLANK | all digits off, counting BLANK_CYCLES before the next digit lights
// ST_SHOW  | selected digit lit, counting DWELL_CYCLES; last cycle of digit 3 ends the frame
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load_req,
  input  logic        lz_en,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [7:0]  Result,
  output logic [3:0]  tube_enables
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit SKIP_BLANK = (BLANK_CYCLES == 0);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  // Without a blank phase the scan must come out of reset already showing digit 0.
  localparam state_t ST_RESET = SKIP_BLANK ? ST_SHOW : ST_BLANK;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [15:0]   shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESET;
      cnt        <= '0;
      digit      <= 2'd0;
      shadow     <= 16'h0000;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            state <= SKIP_BLANK ? ST_SHOW : ST_BLANK;
            if (digit == 2'd3) begin
              frame_tick <= 1'b1;
              if (load_req) begin
                shadow   <= value_in;
                load_ack <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  logic [3:0] nib;
  logic       lz_blank;
  logic       lit;
  logic [7:0] seg;

  always_comb begin
    nib = shadow[{digit, 2'b00} +: 4];
    case (digit)
      2'd1:    lz_blank = (shadow[15:4] == 12'h000);
      2'd2:    lz_blank = (shadow[15:8] == 8'h00);
      2'd3:    lz_blank = (shadow[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    // Gating with rst keeps the tubes dark in reset even when the reset state is ST_SHOW.
    lit = rst && (state == ST_SHOW) && !(lz_en && lz_blank);
  end

  always_comb begin
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  end

  assign Result       = lit ? seg : 8'hFF;
  assign tube_enables = lit ? ~(4'b0001 << digit) : 4'b1111;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with a blank gap, one without.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        load_req = 1'b0;
  logic        lz_en = 1'b0;

  logic       ack0, tick0, ack1, tick1;
  logic [7:0] res0, res1;
  logic [3:0] en0, en1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load_req(load_req), .lz_en(lz_en),
    .load_ack(ack0), .frame_tick(tick0), .Result(res0), .tube_enables(en0)
  );

  seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_skip (
    .clk(clk), .rst(rst), .value_in(value_in), .load_req(load_req), .lz_en(lz_en),
    .load_ack(ack1), .frame_tick(tick1), .Result(res1), .tube_enables(en1)
  );

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Release lands on a falling edge; that clock period is cycle 0.
  task automatic reset_release();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; value_in = 16'hFFFF; load_req = 1'b1; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (en0 !== 4'b1111) begin errors++; $display("FAIL reset_en0 got %b want 1111", en0); end
    checks++; if (res0 !== 8'hFF) begin errors++; $display("FAIL reset_res0 got %h want ff", res0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL reset_tick0 got %b want 0", tick0); end
    checks++; if (en1 !== 4'b1111) begin errors++; $display("FAIL reset_en1 got %b want 1111", en1); end
    checks++; if (res1 !== 8'hFF) begin errors++; $display("FAIL reset_res1 got %h want ff", res1); end
  endtask

  task automatic test_scan();
    logic [3:0] e_en0, e_en1, one;
    logic [7:0] e_res0;
    logic       e_tick0, e_tick1;
    int p, d, d1;
    value_in = 16'h0000; load_req = 1'b0; lz_en = 1'b0;
    reset_release();
    for (int c = 0; c <= 48; c++) begin
      run_to(c);
      p = c % 6;
      d = (c % 24) / 6;
      d1 = (c / 4) % 4;
      one = 4'b0001;
      e_en0  = (p < 2) ? 4'b1111 : ~(one << d);
      e_res0 = (p < 2) ? 8'hFF : 8'hC0;
      e_tick0 = (c == 24) || (c == 48);
      e_en1  = ~(one << d1);
      e_tick1 = (c > 0) && (c % 16 == 0);
      checks++; if (en0 !== e_en0) begin errors++; $display("FAIL scan_en0 cyc %0d got %b want %b", c, en0, e_en0); end
      checks++; if (res0 !== e_res0) begin errors++; $display("FAIL scan_res0 cyc %0d got %h want %h", c, res0, e_res0); end
      checks++; if (tick0 !== e_tick0) begin errors++; $display("FAIL scan_tick0 cyc %0d got %b want %b", c, tick0, e_tick0); end
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL scan_ack0 cyc %0d got %b want 0", c, ack0); end
      checks++; if (en1 !== e_en1) begin errors++; $display("FAIL skip_en1 cyc %0d got %b want %b", c, en1, e_en1); end
      checks++; if (res1 !== 8'hC0) begin errors++; $display("FAIL skip_res1 cyc %0d got %h want c0", c, res1); end
      checks++; if (tick1 !== e_tick1) begin errors++; $display("FAIL skip_tick1 cyc %0d got %b want %b", c, tick1, e_tick1); end
    end
  endtask

  task automatic test_load();
    int         at  [4] = '{26, 32, 38, 44};
    logic [3:0] xen [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] xres[4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    value_in = 16'h12AF; load_req = 1'b1; lz_en = 1'b0;
    reset_release();
    run_to(2);
    checks++; if (res0 !== 8'hC0) begin errors++; $display("FAIL load_pre_res got %h want c0", res0); end
    run_to(16);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL load_skip_ack got %b want 1", ack1); end
    run_to(23);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL load_ack_early got %b want 0", ack0); end
    run_to(24);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL load_ack got %b want 1", ack0); end
    checks++; if (tick0 !== 1'b1) begin errors++; $display("FAIL load_tick got %b want 1", tick0); end
    load_req = 1'b0;
    run_to(25);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL load_ack_width got %b want 0", ack0); end
    checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL load_tick_width got %b want 0", tick0); end
    for (int i = 0; i < 4; i++) begin
      run_to(at[i]);
      checks++; if (en0 !== xen[i]) begin errors++; $display("FAIL load_en d%0d got %b want %b", i, en0, xen[i]); end
      checks++; if (res0 !== xres[i]) begin errors++; $display("FAIL load_res d%0d got %h want %h", i, res0, xres[i]); end
    end
    run_to(48);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL load_noack got %b want 0", ack0); end
    checks++; if (tick0 !== 1'b1) begin errors++; $display("FAIL load_tick2 got %b want 1", tick0); end
  endtask

  // Continues from test_load with 12AF already displayed.
  task automatic test_no_tear();
    run_to(50);
    value_in = 16'h0000;
    run_to(56);
    checks++; if (res0 !== 8'h88) begin errors++; $display("FAIL tear_d1 got %h want 88", res0); end
    run_to(68);
    checks++; if (res0 !== 8'hF9) begin errors++; $display("FAIL tear_d3 got %h want f9", res0); end
    run_to(72);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL tear_ack got %b want 0", ack0); end
    checks++; if (tick0 !== 1'b1) begin errors++; $display("FAIL tear_tick got %b want 1", tick0); end
    run_to(74);
    checks++; if (res0 !== 8'h8E) begin errors++; $display("FAIL tear_d0 got %h want 8e", res0); end
    run_to(76);
    load_req = 1'b1;
    run_to(78);
    load_req = 1'b0;
    run_to(96);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL short_req_ack got %b want 0", ack0); end
    run_to(98);
    checks++; if (res0 !== 8'h8E) begin errors++; $display("FAIL short_req_d0 got %h want 8e", res0); end
  endtask

  task automatic test_lz();
    int         at  [4] = '{26, 32, 38, 44};
    logic [3:0] xen [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [7:0] xres[4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    value_in = 16'h0005; load_req = 1'b1; lz_en = 1'b1;
    reset_release();
    run_to(2);
    checks++; if (en0 !== 4'b1110 || res0 !== 8'hC0) begin errors++; $display("FAIL lz_zero_d0 got %b/%h want 1110/c0", en0, res0); end
    run_to(8);
    checks++; if (en0 !== 4'b1111 || res0 !== 8'hFF) begin errors++; $display("FAIL lz_zero_d1 got %b/%h want 1111/ff", en0, res0); end
    run_to(24);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lz_ack1 got %b want 1", ack0); end
    for (int i = 0; i < 4; i++) begin
      run_to(at[i]);
      checks++; if (en0 !== xen[i]) begin errors++; $display("FAIL lz_en d%0d got %b want %b", i, en0, xen[i]); end
      checks++; if (res0 !== xres[i]) begin errors++; $display("FAIL lz_res d%0d got %h want %h", i, res0, xres[i]); end
    end
    lz_en = 1'b0;
    #1;
    checks++; if (en0 !== 4'b0111 || res0 !== 8'hC0) begin errors++; $display("FAIL lz_live got %b/%h want 0111/c0", en0, res0); end
    run_to(48);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lz_ack2 got %b want 1", ack0); end
    run_to(56);
    checks++; if (en0 !== 4'b1101 || res0 !== 8'hC0) begin errors++; $display("FAIL lz_off_d1 got %b/%h want 1101/c0", en0, res0); end
    run_to(62);
    checks++; if (en0 !== 4'b1011 || res0 !== 8'hC0) begin errors++; $display("FAIL lz_off_d2 got %b/%h want 1011/c0", en0, res0); end
    load_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    value_in = 16'h12AF; load_req = 1'b1; lz_en = 1'b0;
    reset_release();
    run_to(24);
    load_req = 1'b0;
    run_to(38);
    checks++; if (en0 !== 4'b1011 || res0 !== 8'hA4) begin errors++; $display("FAIL mid_pre got %b/%h want 1011/a4", en0, res0); end
    #2 rst = 1'b0;
    #1;
    checks++; if (en0 !== 4'b1111 || res0 !== 8'hFF) begin errors++; $display("FAIL mid_rst_out got %b/%h want 1111/ff", en0, res0); end
    checks++; if (ack0 !== 1'b0 || tick0 !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses got %b/%b want 0/0", ack0, tick0); end
    reset_release();
    run_to(2);
    checks++; if (en0 !== 4'b1110 || res0 !== 8'hC0) begin errors++; $display("FAIL mid_restart_d0 got %b/%h want 1110/c0", en0, res0); end
    run_to(8);
    checks++; if (en0 !== 4'b1101 || res0 !== 8'hC0) begin errors++; $display("FAIL mid_restart_d1 got %b/%h want 1101/c0", en0, res0); end
    load_req = 1'b1;
    run_to(23);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0 || tick0 !== 1'b0) begin errors++; $display("FAIL pending_ack got %b/%b want 0/0", ack0, tick0); end
    load_req = 1'b0;
    reset_release();
    run_to(2);
    checks++; if (res0 !== 8'hC0) begin errors++; $display("FAIL pending_shadow got %h want c0", res0); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_no_tear();
    test_lz();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000: clk cycles each digit is lit; legal range >=1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500: all-off cycles before each digit; 0 means the blank phase is skipped.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port value_in, input, 16 bits: the value to display, four hex nibbles.
REQ-006 SHALL have port load_req, input, 1 bit: level request to capture value_in.
REQ-007 SHALL have port lz_en, input, 1 bit: leading-zero blanking enable.
REQ-008 SHALL have port load_ack, output, 1 bit: one-cycle pulse confirming a capture.
REQ-009 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-010 SHALL have port Result, output, 8 bits: segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port tube_enables, output, 4 bits: digit enables, active-low; bit n drives digit n.

Function
REQ-012 SHALL implement the state machine BLANK -> SHOW -> BLANK, with a cycle counter and a 2-bit digit register.
REQ-013 In BLANK, the counter SHALL run 0..BLANK_CYCLES-1; at count BLANK_CYCLES-1 the state SHALL go to SHOW and the counter SHALL clear.
REQ-014 When BLANK_CYCLES=0, BLANK SHALL be bypassed and the digit advance SHALL go straight to SHOW.
REQ-015 In SHOW, the counter SHALL run 0..DWELL_CYCLES-1; at count DWELL_CYCLES-1 the digit SHALL advance and the state SHALL go to BLANK.
REQ-016 Digit advance SHALL wrap from 3 to 0.
REQ-017 Frame length SHALL be exactly 4*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-018 A 16-bit shadow register SHALL hold the displayed value; digit n SHALL show shadow[4n+3:4n].
REQ-019 The frame boundary SHALL be the last SHOW cycle of digit 3.
REQ-020 At the frame boundary, if load_req=1, the shadow register SHALL load value_in; at no other time SHALL it change (no tearing).
REQ-021 load_ack SHALL pulse high for exactly one cycle, in the cycle after a capture.
REQ-022 frame_tick SHALL pulse in the cycle after every frame boundary, whether or not a capture occurred.
REQ-023 load_req held high across frames SHALL cause a capture and an ack every frame.
REQ-024 A load_req that rises and falls within one frame, not high at the boundary, SHALL be ignored.
REQ-025 In BLANK: tube_enables SHALL be 4'b1111 and Result SHALL be 8'hFF.
REQ-026 In SHOW: only tube_enables[digit] SHALL be 0, and Result SHALL be the decode of the selected nibble with dp=1.
REQ-027 The decode SHALL be, for nibbles 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex).
REQ-028 With lz_en=1, digit n>0 SHALL be blanked when shadow nibbles n..3 are all zero: enable stays 1 and Result is 8'hFF.
REQ-029 Digit 0 SHALL never be blanked.
REQ-030 lz_en SHALL be sampled continuously; its effect SHALL apply within the current SHOW cycle.
REQ-031 Result and tube_enables SHALL decode only from the state, digit, shadow and lz_en registers/inputs.
REQ-032 There SHALL be no combinational path from value_in or load_req to any output.

Reset
REQ-033 While rst=0: state=BLANK, counter=0, digit=0, shadow=16'h0000.
REQ-034 While rst=0: load_ack=0, frame_tick=0, tube_enables=4'b1111, Result=8'hFF.
REQ-035 Reset asserted mid-frame SHALL take effect immediately; no pending ack SHALL survive it.
REQ-036 After rst rises, the first frame SHALL start in BLANK for digit 0 (SHOW for digit 0 when BLANK_CYCLES=0).

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated)
REQ-037 Reset release, load_req=0 -> cycles 0-1 enables 1111; cycles 2-5 enables 1110 with Result C0; digits 1, 2, 3 follow; frame_tick high at cycle 24; period 24 cycles.
REQ-038 value_in=16'h12AF, load_req=1 through the first boundary -> load_ack and frame_tick high at cycle 24; next frame shows digit 0 = 8E, digit 1 = 88, digit 2 = A4, digit 3 = F9.
REQ-039 value_in changes to 16'h0000 mid-frame with load_req=0 -> displayed segments unchanged; no load_ack.
REQ-040 shadow=16'h0005, lz_en=1 -> digits 1-3 show enables 1111 with Result FF; digit 0 shows 92 with enable 1110; lz_en=0 -> digits 1-3 show C0.
REQ-041 rst pulsed low during digit 2 SHOW -> outputs 1111/FF immediately; shadow cleared; the scan restarts at digit 0.
REQ-042 BLANK_CYCLES=0 -> enables never 1111 after reset; digit changes every 4 cycles; frame period 16 cycles.
